// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter and detector blocks.
package seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StShift = ST_SHIFT,
        StGap   = ST_GAP
    } tx_state_e;

    // Bits needed to hold a length of 0..width.
    function automatic int unsigned len_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_tx_shift_reg.sv
// Left-aligning load/shift register with a down counter of bits still to present.
// On load the MSB of the word is offered on first_bit and the rest is kept for shifting.
module seq_tx_shift_reg
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic                          shift,
    input  logic [WIDTH-1:0]              load_data,
    input  logic [len_width(WIDTH)-1:0]   load_len,
    output logic                          first_bit,
    output logic                          cur_bit,
    output logic                          count_one
);

    localparam int unsigned LW = len_width(WIDTH);

    logic [WIDTH-1:0] aligned;
    logic [WIDTH-1:0] data_q, data_d;
    logic [LW-1:0]    count_q, count_d;

    // load_len is always 1..WIDTH here; the used field is moved up to the MSB end.
    always_comb begin
        aligned = load_data << (LW'(WIDTH) - load_len);
        data_d  = data_q;
        count_d = count_q;
        if (load) begin
            data_d  = aligned << 1;
            count_d = load_len - 1'b1;
        end else if (shift && (count_q != '0)) begin
            data_d  = data_q << 1;
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign first_bit = aligned[WIDTH-1];
    assign cur_bit   = data_q[WIDTH-1];
    assign count_one = (count_q == LW'(1));

endmodule

// File: rtl/seq_pattern_tx_fsm.sv
// Serial pattern transmitter: accepts a 1..WIDTH bit word over valid/ready and sends it
// MSB-first on dout, followed by GAP_CYCLES idle cycles. All outputs are registered.
module seq_pattern_tx_fsm
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [WIDTH-1:0]              in_data,
    input  logic [len_width(WIDTH)-1:0]   in_len,
    output logic                          in_ready,
    output logic                          dout,
    output logic                          dout_valid,
    output logic                          dout_last,
    output logic                          busy
);

    localparam int unsigned LW   = len_width(WIDTH);
    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    tx_state_e       state_q, state_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic            in_ready_q, in_ready_d;
    logic            dout_q, dout_d;
    logic            dout_valid_q, dout_valid_d;
    logic            dout_last_q, dout_last_d;
    logic            busy_q, busy_d;

    logic [LW-1:0]   eff_len;
    logic            sr_load, sr_shift;
    logic            sr_first_bit, sr_cur_bit, sr_count_one;

    assign eff_len = ((in_len == '0) || (in_len > LW'(WIDTH))) ? LW'(WIDTH) : in_len;

    seq_tx_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (sr_load),
        .shift     (sr_shift),
        .load_data (in_data),
        .load_len  (eff_len),
        .first_bit (sr_first_bit),
        .cur_bit   (sr_cur_bit),
        .count_one (sr_count_one)
    );

    // Output flops are loaded one step ahead: dout_last_q marks the bit now on dout as
    // the final one, so the next edge leaves SHIFT.
    always_comb begin
        state_d      = state_q;
        gap_d        = gap_q;
        sr_load      = 1'b0;
        sr_shift     = 1'b0;
        dout_d       = 1'b0;
        dout_valid_d = 1'b0;
        dout_last_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready_q) begin
                    sr_load      = 1'b1;
                    state_d      = StShift;
                    dout_d       = sr_first_bit;
                    dout_valid_d = 1'b1;
                    dout_last_d  = (eff_len == LW'(1));
                end
            end
            StShift: begin
                if (dout_last_q) begin
                    gap_d = '0;
                    if (GAP_CYCLES > 0) begin
                        state_d = StGap;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    sr_shift     = 1'b1;
                    dout_d       = sr_cur_bit;
                    dout_valid_d = 1'b1;
                    dout_last_d  = sr_count_one;
                end
            end
            StGap: begin
                if (int'(gap_q) == int'(GAP_CYCLES) - 1) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        in_ready_d = (state_d == StIdle);
        busy_d     = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            gap_q        <= '0;
            in_ready_q   <= 1'b1;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            in_ready_q   <= in_ready_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            busy_q       <= busy_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_seq_pattern_tx_fsm.sv
// Directed bench: table of words for a GAP_CYCLES=2 instance, plus hand sequences for
// reset, back-to-back words on a GAP_CYCLES=0 instance, and reset mid-word.
module tb_seq_pattern_tx_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       valid = 1'b0;
    logic [7:0] data  = '0;
    logic [3:0] len   = '0;
    logic       rdy, dout, dv, last, busy;

    logic       v0 = 1'b0;
    logic [7:0] d0 = '0;
    logic [3:0] l0 = '0;
    logic       rdy0, dout0, dv0, last0, busy0;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [7:0] data;
        logic [3:0] len;
        int         exp_len;
        logic [7:0] exp_bits;
        logic       exp_det;
    } vec_t;

    vec_t vecs[8];

    logic [3:0] b2b_exp[6];

    always #5 clk = ~clk;

    seq_pattern_tx_fsm #(
        .WIDTH      (8),
        .GAP_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (valid),
        .in_data    (data),
        .in_len     (len),
        .in_ready   (rdy),
        .dout       (dout),
        .dout_valid (dv),
        .dout_last  (last),
        .busy       (busy)
    );

    seq_pattern_tx_fsm #(
        .WIDTH      (8),
        .GAP_CYCLES (0)
    ) dut0 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (v0),
        .in_data    (d0),
        .in_len     (l0),
        .in_ready   (rdy0),
        .dout       (dout0),
        .dout_valid (dv0),
        .dout_last  (last0),
        .busy       (busy0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (rdy !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("ready_wait", {31'b0, rdy}, 32'd1);
    endtask

    // Sends one word on dut and checks every bit, the 101 detector on the last bit,
    // the gap and the return to idle.
    task automatic send(input vec_t v, input int idx);
        logic [1:0] ds;
        logic       bit_e;
        logic       det;
        wait_ready();
        valid = 1'b1;
        data  = v.data;
        len   = v.len;
        tick();
        valid = 1'b0;
        data  = ~v.data;
        len   = 4'(idx + 3);
        ds    = 2'd0;
        for (int i = 0; i < v.exp_len; i++) begin
            if (i > 0) tick();
            bit_e = v.exp_bits[v.exp_len-1-i];
            chk($sformatf("v%0d_bit%0d {dv,dout,last,rdy}", idx, i),
                {28'b0, dv, dout, last, rdy},
                {28'b0, 1'b1, bit_e, (i == v.exp_len - 1), 1'b0});
            // Overlapping Mealy 101 detector fed by the stream.
            det = (ds == 2'd2) && dout;
            case (ds)
                2'd0:    ds = dout ? 2'd1 : 2'd0;
                2'd1:    ds = dout ? 2'd1 : 2'd2;
                default: ds = dout ? 2'd1 : 2'd0;
            endcase
            if (i == v.exp_len - 1)
                chk($sformatf("v%0d_detect101", idx), {31'b0, det}, {31'b0, v.exp_det});
        end
        for (int g = 0; g < 2; g++) begin
            tick();
            chk($sformatf("v%0d_gap%0d {dv,dout,last,rdy,busy}", idx, g),
                {27'b0, dv, dout, last, rdy, busy}, {27'b0, 5'b00001});
        end
        tick();
        chk($sformatf("v%0d_idle {dv,rdy,busy}", idx), {29'b0, dv, rdy, busy},
            {29'b0, 3'b010});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h05, 4'd3,  3, 8'h05, 1'b1};
        vecs[1] = '{8'hA5, 4'd0,  8, 8'hA5, 1'b1};
        vecs[2] = '{8'h3C, 4'd12, 8, 8'h3C, 1'b0};
        vecs[3] = '{8'hFF, 4'd1,  1, 8'h01, 1'b0};
        vecs[4] = '{8'hFE, 4'd1,  1, 8'h00, 1'b0};
        vecs[5] = '{8'hF6, 4'd4,  4, 8'h06, 1'b0};
        vecs[6] = '{8'hC1, 4'd7,  7, 8'h41, 1'b0};
        vecs[7] = '{8'h5A, 4'd15, 8, 8'h5A, 1'b0};

        // {dv,dout,last,rdy} per cycle for words 2'b11 then 2'b10, GAP_CYCLES=0
        b2b_exp[0] = 4'b1100;
        b2b_exp[1] = 4'b1110;
        b2b_exp[2] = 4'b0001;
        b2b_exp[3] = 4'b1100;
        b2b_exp[4] = 4'b1010;
        b2b_exp[5] = 4'b0001;

        // Reset held two cycles
        rst = 1'b1;
        for (int r = 0; r < 2; r++) begin
            tick();
            chk($sformatf("reset%0d {rdy,dout,dv,last,busy}", r),
                {27'b0, rdy, dout, dv, last, busy}, {27'b0, 5'b10000});
            chk($sformatf("reset%0d_g0 {rdy,dout,dv,last,busy}", r),
                {27'b0, rdy0, dout0, dv0, last0, busy0}, {27'b0, 5'b10000});
        end
        rst = 1'b0;
        tick();

        for (int k = 0; k < 8; k++) send(vecs[k], k);

        // Back-to-back words with in_valid held high
        v0 = 1'b1;
        d0 = 8'h03;
        l0 = 4'd2;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c == 0) d0 = 8'h02;
            if (c == 3) v0 = 1'b0;
            chk($sformatf("b2b_c%0d {dv,dout,last,rdy}", c),
                {28'b0, dv0, dout0, last0, rdy0}, {28'b0, b2b_exp[c]});
        end
        tick();
        chk("b2b_no_extra {dv,busy}", {30'b0, dv0, busy0}, 32'd0);

        // Reset on the 2nd bit of an 8-bit word
        wait_ready();
        valid = 1'b1;
        data  = 8'hFF;
        len   = 4'd0;
        tick();
        valid = 1'b0;
        chk("abort_bit0 {dv,dout,last}", {29'b0, dv, dout, last}, {29'b0, 3'b110});
        tick();
        chk("abort_bit1 {dv,dout,last}", {29'b0, dv, dout, last}, {29'b0, 3'b110});
        rst = 1'b1;
        tick();
        chk("abort_rst {dv,dout,last,rdy,busy}", {27'b0, dv, dout, last, rdy, busy},
            {27'b0, 5'b00010});
        rst = 1'b0;
        tick();
        chk("abort_after {dv,dout,last,rdy,busy}", {27'b0, dv, dout, last, rdy, busy},
            {27'b0, 5'b00010});
        send('{8'h80, 4'd8, 8, 8'h80, 1'b0}, 8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
